// File: rtl/flash_read_scheduler.sv
// Round-robin scheduler sharing one SPI NOR flash (READ 0x03, mode 0, SCLK = clk/2)
// between two read clients; received bytes are tagged with the owning client id.
module flash_read_scheduler #(
    parameter int CS_IDLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [23:0] addr0,
    input  logic [7:0]  len0,
    output logic        ack0,
    input  logic        req1,
    input  logic [23:0] addr1,
    input  logic [7:0]  len1,
    output logic        ack1,
    output logic [7:0]  dataOut,
    output logic        dataValid,
    output logic        dataClient,
    output logic        dataLast,
    output logic        busy,
    output logic        flashClk,
    output logic        flashMosi,
    output logic        flashCs,
    input  logic        flashMiso
);
    localparam int GW = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    len_q, len_d;
    logic          client_q, client_d;
    logic          last_grant_q, last_grant_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          data_client_q, data_client_d;
    logic          data_last_q, data_last_d;
    logic          busy_q, busy_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
    logic          gnt;

    // When both clients ask, the one not served last time wins.
    assign gnt = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_d          = rx_q;
        byte_cnt_d    = byte_cnt_q;
        len_d         = len_q;
        client_d      = client_q;
        last_grant_d  = last_grant_q;
        gap_cnt_d     = gap_cnt_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        data_client_d = data_client_q;
        data_last_d   = 1'b0;
        busy_d        = busy_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        cs_d          = cs_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    ack0_d       = ~gnt;
                    ack1_d       = gnt;
                    client_d     = gnt;
                    last_grant_d = gnt;
                    len_d        = gnt ? len1 : len0;
                    shift_d      = {8'h03, (gnt ? addr1 : addr0)};
                    mosi_d       = 1'b0;
                    sclk_d       = 1'b0;
                    cs_d         = 1'b0;
                    phase_d      = 1'b0;
                    bit_cnt_d    = 5'd0;
                    byte_cnt_d   = 8'd0;
                    busy_d       = 1'b1;
                    state_d      = S_CMD;
                end
            end
            S_CMD, S_ADDR: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    shift_d   = shift_q << 1;
                    mosi_d    = shift_q[30];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        state_d = S_ADDR;
                    end
                    // The 5-bit counter wraps to 0 here and then counts bits within each byte.
                    if (bit_cnt_q == 5'd31) begin
                        state_d = S_DATA;
                        mosi_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    phase_d   = 1'b0;
                    sclk_d    = 1'b0;
                    rx_d      = {rx_q[6:0], flashMiso};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q[2:0] == 3'd7) begin
                        data_out_d    = {rx_q[6:0], flashMiso};
                        data_valid_d  = 1'b1;
                        data_client_d = client_q;
                        if (byte_cnt_q == len_q) begin
                            data_last_d = 1'b1;
                            cs_d        = 1'b1;
                            gap_cnt_d   = '0;
                            state_d     = S_GAP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 32'd0;
            rx_q          <= 8'd0;
            byte_cnt_q    <= 8'd0;
            len_q         <= 8'd0;
            client_q      <= 1'b0;
            last_grant_q  <= 1'b1;
            gap_cnt_q     <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            data_out_q    <= 8'd0;
            data_valid_q  <= 1'b0;
            data_client_q <= 1'b0;
            data_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            cs_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_q          <= rx_d;
            byte_cnt_q    <= byte_cnt_d;
            len_q         <= len_d;
            client_q      <= client_d;
            last_grant_q  <= last_grant_d;
            gap_cnt_q     <= gap_cnt_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            data_client_q <= data_client_d;
            data_last_q   <= data_last_d;
            busy_q        <= busy_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            cs_q          <= cs_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign dataOut    = data_out_q;
    assign dataValid  = data_valid_q;
    assign dataClient = data_client_q;
    assign dataLast   = data_last_q;
    assign busy       = busy_q;
    assign flashClk   = sclk_q;
    assign flashMosi  = mosi_q;
    assign flashCs    = cs_q;
endmodule

// File: tb/tb_flash_read_scheduler.sv
// Directed bench for flash_read_scheduler: table of single-client reads plus hand sequences
// for contention, reset mid-transfer and a request raised during a transfer.
module tb_flash_read_scheduler;
    localparam int CSI = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic [7:0]  len0 = '0, len1 = '0;
    logic        ack0, ack1;
    logic [7:0]  dataOut;
    logic        dataValid, dataClient, dataLast, busy;
    logic        flashClk, flashMosi, flashCs;
    logic        flashMiso = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int viol = 0;
    int gl[$];

    flash_read_scheduler #(.CS_IDLE_CYCLES(CSI)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .len0(len0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .len1(len1), .ack1(ack1),
        .dataOut(dataOut), .dataValid(dataValid), .dataClient(dataClient),
        .dataLast(dataLast), .busy(busy),
        .flashClk(flashClk), .flashMosi(flashMosi), .flashCs(flashCs), .flashMiso(flashMiso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_byte(input logic [23:0] x);
        return x[7:0] ^ x[15:8] ^ x[23:16] ^ 8'h5A;
    endfunction

    // Flash model: captures 32 command/address bits on SCLK rise, drives data on SCLK fall.
    int          f_cnt = 0;
    logic [31:0] f_sh = '0;
    logic [31:0] last_cmd = '0;
    logic        prev_sclk = 1'b0;
    always @(negedge clk) begin
        logic [7:0] mb;
        int d;
        if (flashCs) begin
            f_cnt = 0;
            flashMiso = 1'b0;
        end else if (flashClk && !prev_sclk) begin
            if (f_cnt < 32) f_sh = {f_sh[30:0], flashMosi};
            f_cnt = f_cnt + 1;
            if (f_cnt == 32) last_cmd = f_sh;
        end else if (!flashClk && prev_sclk && f_cnt >= 32) begin
            d = f_cnt - 32;
            mb = model_byte(f_sh[23:0] + 24'(d / 8));
            flashMiso = mb[7 - (d % 8)];
        end
        prev_sclk = flashClk;
    end

    always @(negedge clk) begin
        if (ack0 && ack1) viol = viol + 1;
        if (dataValid && !busy) viol = viol + 1;
        if (ack0) gl.push_back(0);
        if (ack1) gl.push_back(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic run_txn(input bit cl, input logic [23:0] a, input logic [7:0] l,
                           input logic [7:0] exp_first, input string nm);
        int ack_cyc, first_cyc, prev_cyc, nbytes, bad_space, bad_byte, bad_cl, bad_last, cs_low;
        logic got_ack;
        logic [7:0] eb;
        ack_cyc = 0; first_cyc = 0; prev_cyc = 0; nbytes = 0;
        bad_space = 0; bad_byte = 0; bad_cl = 0; bad_last = 0; cs_low = 0;
        got_ack = 1'b0;
        @(negedge clk);
        if (cl) begin req1 = 1'b1; addr1 = a; len1 = l; end
        else    begin req0 = 1'b1; addr0 = a; len0 = l; end
        for (int t = 0; t < 200 && !got_ack; t++) begin
            @(negedge clk);
            if (cl ? ack1 : ack0) begin got_ack = 1'b1; ack_cyc = cyc; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk({nm, ".ack"}, 32'(got_ack), 32'd1);
        for (int t = 0; t < (int'(l) + 1) * 16 + 200; t++) begin
            @(negedge clk);
            if (dataValid) begin
                nbytes = nbytes + 1;
                if (nbytes == 1) first_cyc = cyc;
                else if (cyc - prev_cyc != 16) bad_space = bad_space + 1;
                prev_cyc = cyc;
                eb = (nbytes == 1) ? exp_first : model_byte(a + 24'(nbytes - 1));
                if (dataOut !== eb) bad_byte = bad_byte + 1;
                if (dataClient !== cl) bad_cl = bad_cl + 1;
                if (dataLast !== (nbytes == int'(l) + 1)) bad_last = bad_last + 1;
                if (dataLast) break;
            end
        end
        chk({nm, ".cmd"}, last_cmd, {8'h03, a});
        chk({nm, ".bytes"}, 32'(nbytes), 32'(int'(l) + 1));
        chk({nm, ".latency"}, 32'(first_cyc - ack_cyc), 32'd80);
        chk({nm, ".data"}, 32'(bad_byte + bad_space + bad_cl + bad_last), 32'd0);
        for (int t = 0; t < CSI; t++) begin
            if (flashCs !== 1'b1) cs_low = cs_low + 1;
            @(negedge clk);
        end
        chk({nm, ".gap_cs"}, 32'(cs_low), 32'd0);
    endtask

    typedef struct {
        bit          client;
        logic [23:0] addr;
        logic [7:0]  len;
        logic [7:0]  first;
        string       name;
    } vec_t;

    initial begin
        vec_t vt[5];
        int n, last_cyc, ack_cyc, cs_low;
        logic seen;
        vt[0] = '{1'b0, 24'h000100, 8'd0,   8'h5B, "single_c0"};
        vt[1] = '{1'b1, 24'h123456, 8'd3,   8'h2A, "burst_c1"};
        vt[2] = '{1'b0, 24'hFFFFFE, 8'd2,   8'hA4, "wrap_c0"};
        vt[3] = '{1'b0, 24'h00AB00, 8'd255, 8'hF1, "maxlen_c0"};
        vt[4] = '{1'b1, 24'hA5A5A5, 8'd0,   8'hFF, "single_c1"};

        // Reset state; both requests already high so they contend on release.
        req0 = 1'b1; req1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.outputs",
            {dataOut, 1'b0, dataClient, dataLast, dataValid, ack0, ack1, busy, flashCs, flashClk, flashMosi},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        gl.delete();
        reset = 1'b0;
        for (int t = 0; t < 3000 && gl.size() < 4; t++) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        chk("contention.count", 32'(gl.size()), 32'd4);
        if (gl.size() >= 4) chk("contention.order", {gl[0], gl[1], gl[2], gl[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
        for (int t = 0; t < 500 && busy; t++) @(negedge clk);
        chk("contention.idle", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) run_txn(vt[i].client, vt[i].addr, vt[i].len, vt[i].first, vt[i].name);

        // Reset after the second of four bytes.
        @(negedge clk);
        req0 = 1'b1; addr0 = 24'h000050; len0 = 8'd3;
        n = 0;
        for (int t = 0; t < 400 && n < 2; t++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (dataValid) n = n + 1;
        end
        req0 = 1'b0;
        chk("rstmid.bytes_before", 32'(n), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.cs_busy_dv", {flashCs, busy, dataValid, dataLast}, {1'b1, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (dataValid || dataLast || busy) n = n + 1;
        end
        chk("rstmid.quiet", 32'(n), 32'd0);
        run_txn(1'b0, 24'h000200, 8'd1, 8'h58, "restart_c0");

        // Late request: req1 raised during client 0 DATA.
        @(negedge clk);
        req0 = 1'b1; addr0 = 24'h000300; len0 = 8'd1;
        seen = 1'b0; last_cyc = 0; ack_cyc = 0; cs_low = 0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (dataValid) begin req1 = 1'b1; addr1 = 24'h000400; len1 = 8'd0; end
            if (ack1) chk("late.early_ack1", 32'd1, 32'd0);
            if (dataLast) begin seen = 1'b1; last_cyc = cyc; end
        end
        chk("late.last_seen", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (flashCs !== 1'b1) cs_low = cs_low + 1;
            @(negedge clk);
            if (ack1) begin seen = 1'b1; ack_cyc = cyc; end
        end
        req1 = 1'b0;
        chk("late.ack1_seen", 32'(seen), 32'd1);
        chk("late.ack1_delay", 32'(ack_cyc - last_cyc), 32'(CSI + 1));
        chk("late.gap_cs", 32'(cs_low), 32'd0);
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (dataLast) seen = 1'b1;
        end
        chk("late.c1_done", {31'd0, seen}, 32'd1);
        chk("late.c1_cmd", last_cmd, 32'h03000400);

        chk("invariants", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
